reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Sequences and shares the single write port of the register file between the ALU writeback stage and the load/store unit (LSU) writeback. After reset it first runs a clear sweep that writes zero to x1..x(REG_COUNT-1). It then arbitrates the two writeback requesters round-robin over valid/ready handshakes and drives the register file's write enable, destination and write data from registered outputs.

## Interface
- DATA_WIDTH, 32, width of writeback data and of the register file data port
- CLEAR_ON_RESET, 1, 1 = run the zeroing sweep after reset; 0 = go directly to arbitration
- clk  input  1  system clock; all state updates on rising edge
- rstN  input  1  reset, asynchronous, active-low
- alu_valid  input  1  ALU writeback request
- alu_rd  input  regName_t  ALU destination register
- alu_data  input  DATA_WIDTH  ALU result
- alu_ready  output  1  ALU request accepted this cycle when alu_valid && alu_ready
- lsu_valid  input  1  LSU writeback request
- lsu_rd  input  regName_t  LSU destination register
- lsu_data  input  DATA_WIDTH  load data
- lsu_ready  output  1  LSU request accepted this cycle when lsu_valid && lsu_ready
- rf_wen  output  1  register file write enable, registered
- rf_rd  output  regName_t  register file destination, registered
- rf_data  output  DATA_WIDTH  register file write data, registered
- clear_busy  output  1  high while the clear sweep is running
- last_grant  output  1  0 = ALU, 1 = LSU; requester granted most recently

## Operation
- FSM states: CLEAR and RUN.
- On reset the FSM enters CLEAR if CLEAR_ON_RESET = 1, otherwise RUN.
- CLEAR state:
  - A 5-bit counter starts at 1.
  - Each cycle the arbiter registers rf_wen = 1, rf_rd = counter, rf_data = 0, then increments the counter.
  - After the cycle with counter = REG_COUNT-1 (31), the FSM moves to RUN.
  - clear_busy = 1 and both ready outputs = 0 for the whole state.
- RUN state:
  - clear_busy = 0.
  - Only the ALU is valid: alu_ready = 1, lsu_ready = 0.
  - Only the LSU is valid: lsu_ready = 1, alu_ready = 0.
  - Both are valid: the requester other than last_grant is granted; the other's ready = 0.
  - Neither is valid: both readies = 1, nothing is accepted, last_grant holds.
  - Ready outputs are combinational from the valids, last_grant and the FSM state. They never depend on the rf_* outputs; the register file never backpressures.
- On an accepted request:
  - Next rising edge: rf_rd and rf_data load the winner's rd and data; last_grant loads the winner.
  - rf_wen = 1, except rf_wen = 0 when the winner's rd = x0. The request is still accepted and still updates last_grant.
- No request accepted: rf_wen = 0 on the next edge. rf_rd and rf_data hold their previous values.
- Data width: data passes through unmodified. No arithmetic except the clear counter increment, which never wraps: it stops at 31.

## Timing
- Reset values, applied asynchronously while rstN = 0: rf_wen = 0, rf_rd = 0, rf_data = 0, last_grant = 1 (LSU), so the ALU wins the first tie. Also: clear counter = 1; clear_busy = 1 if CLEAR_ON_RESET, else 0; both readies = 0 while rstN = 0.
- Latency: a request accepted at rising edge N appears on rf_* after edge N. The register file captures it at the falling edge in cycle N..N+1.
- The rf_* outputs are stable across the falling edge by construction.
- Clear sweep length:
  - First rf_wen pulse (rf_rd = 1) follows the first rising edge after rstN deasserts.
  - The sweep occupies exactly 31 consecutive cycles, rf_rd = 1..31.
  - readies rise in the cycle after the rd = 31 write is registered.
- Back-to-back: a requester can be accepted every cycle. With both valid continuously, grants alternate ALU, LSU, ALU, ...
- Reset mid-sweep or mid-run: all outputs go to their reset values immediately. Any in-flight registered write is dropped. The sweep restarts from rd = 1.
- Valids seen during CLEAR are not accepted. Requesters must hold valid, rd and data stable until accepted.

## Test plan
- Reset then idle, CLEAR_ON_RESET = 1 -> rf_wen high for 31 cycles with rf_rd = 1..31 and rf_data = 0; clear_busy falls after rd = 31; readies are 0 throughout.
- Post-clear, alu_valid with alu_rd = 5, alu_data = 0xDEADBEEF, no LSU -> alu_ready = 1; next cycle rf_wen = 1, rf_rd = 5, rf_data = 0xDEADBEEF; last_grant = 0.
- Both valid for 4 cycles (ALU rd = 3 data = 0x11, LSU rd = 7 data = 0x22) -> rf_rd sequence 3, 7, 3, 7; ready toggles accordingly.
- LSU only, lsu_rd = 0, data = 0xFFFFFFFF -> lsu_ready = 1; next cycle rf_wen = 0; last_grant = 1.
- rstN pulsed low at sweep cycle 10 -> rf_wen drops asynchronously; the sweep restarts at rf_rd = 1 and runs the full 31 cycles.
- CLEAR_ON_RESET = 0, ALU valid in the first cycle after reset with rd = 9, data = 0x1 -> accepted immediately; rf_rd = 9 the next cycle; clear_busy is never 1.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: zeroes x1..x31 after reset, then
// shares the single write port between ALU and LSU writeback round-robin.
package reg_write_arbiter_pkg;
   typedef logic [4:0] regName_t;
   localparam int unsigned REG_COUNT = 32;
endpackage

module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  alu_valid,
   input  regName_t              alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   output logic                  alu_ready,
   input  logic                  lsu_valid,
   input  regName_t              lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   output logic                  lsu_ready,
   output logic                  rf_wen,
   output regName_t              rf_rd,
   output logic [DATA_WIDTH-1:0] rf_data,
   output logic                  clear_busy,
   output logic                  last_grant
);

   typedef enum logic {CLEAR, RUN} state_t;

   localparam regName_t LAST_REG    = regName_t'(REG_COUNT - 1);
   localparam state_t   RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

   state_t   state;
   state_t   state_next;
   regName_t clr_cnt;
   logic     alu_acc;
   logic     lsu_acc;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state <= RESET_STATE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         CLEAR:   if (clr_cnt == LAST_REG) state_next = RUN;
         RUN:     state_next = RUN;
         default: state_next = RESET_STATE;
      endcase
   end

   // Readies are gated by rstN so they read 0 during reset even when the
   // reset state is RUN.
   always_comb begin
      clear_busy = 1'b0;
      alu_ready  = 1'b0;
      lsu_ready  = 1'b0;
      if (state == CLEAR) begin
         clear_busy = 1'b1;
      end else if (rstN) begin
         if (alu_valid && lsu_valid) begin
            alu_ready = last_grant;
            lsu_ready = ~last_grant;
         end else begin
            alu_ready = ~lsu_valid;
            lsu_ready = ~alu_valid;
         end
      end
   end

   assign alu_acc = alu_valid & alu_ready;
   assign lsu_acc = lsu_valid & lsu_ready;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         clr_cnt    <= regName_t'(1);
         rf_wen     <= 1'b0;
         rf_rd      <= '0;
         rf_data    <= '0;
         last_grant <= 1'b1;
      end else if (state == CLEAR) begin
         rf_wen  <= 1'b1;
         rf_rd   <= clr_cnt;
         rf_data <= '0;
         if (clr_cnt != LAST_REG) clr_cnt <= clr_cnt + regName_t'(1);
      end else if (alu_acc) begin
         rf_wen     <= (alu_rd != '0);
         rf_rd      <= alu_rd;
         rf_data    <= alu_data;
         last_grant <= 1'b0;
      end else if (lsu_acc) begin
         rf_wen     <= (lsu_rd != '0);
         rf_rd      <= lsu_rd;
         rf_data    <= lsu_data;
         last_grant <= 1'b1;
      end else begin
         rf_wen <= 1'b0;
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a driver predicts each cycle's
// outputs from a behavioural model, a negedge monitor compares them.
module tb_reg_write_arbiter;
   import reg_write_arbiter_pkg::*;

   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstN;
   logic          alu_valid, lsu_valid, alu_ready, lsu_ready;
   regName_t      alu_rd, lsu_rd, rf_rd;
   logic [DW-1:0] alu_data, lsu_data, rf_data;
   logic          rf_wen, clear_busy, last_grant;

   logic          rstN_z;
   logic          alu_valid_z, lsu_valid_z, alu_ready_z, lsu_ready_z;
   regName_t      alu_rd_z, lsu_rd_z, rf_rd_z;
   logic [DW-1:0] alu_data_z, lsu_data_z, rf_data_z;
   logic          rf_wen_z, clear_busy_z, last_grant_z;

   reg_write_arbiter #(.DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .rstN(rstN),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data(rf_data),
      .clear_busy(clear_busy), .last_grant(last_grant)
   );

   reg_write_arbiter #(.DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b0)) dut_z (
      .clk(clk), .rstN(rstN_z),
      .alu_valid(alu_valid_z), .alu_rd(alu_rd_z), .alu_data(alu_data_z), .alu_ready(alu_ready_z),
      .lsu_valid(lsu_valid_z), .lsu_rd(lsu_rd_z), .lsu_data(lsu_data_z), .lsu_ready(lsu_ready_z),
      .rf_wen(rf_wen_z), .rf_rd(rf_rd_z), .rf_data(rf_data_z),
      .clear_busy(clear_busy_z), .last_grant(last_grant_z)
   );

   typedef struct {
      bit        wen;
      bit [4:0]  rd;
      bit [31:0] data;
      bit        lg;
      bit        busy;
      bit        rdy_a;
      bit        rdy_l;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   bit   mon_en = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   busy_z_seen = 1'b0;

   // Behavioural model: sweep position plus the visible write-port state.
   bit        m_inclear, m_wen, m_lg;
   bit [4:0]  m_cnt, m_rd;
   bit [31:0] m_data;
   bit        p_acc_a, p_acc_l;
   bit [4:0]  p_rd_a, p_rd_l;
   bit [31:0] p_d_a, p_d_l;

   // Random requesters hold a request until the model says it was taken.
   bit        ga_pend, gl_pend;
   bit [4:0]  ga_rd, gl_rd;
   bit [31:0] ga_d, gl_d;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_inclear = 1'b1;
      m_cnt     = 5'd1;
      m_wen     = 1'b0;
      m_rd      = '0;
      m_data    = '0;
      m_lg      = 1'b1;
      p_acc_a   = 1'b0;
      p_acc_l   = 1'b0;
   endfunction

   function automatic void model_step();
      if (m_inclear) begin
         m_wen  = 1'b1;
         m_rd   = m_cnt;
         m_data = '0;
         if (m_cnt == 5'd31) m_inclear = 1'b0;
         else m_cnt = m_cnt + 5'd1;
      end else if (p_acc_a) begin
         m_wen = (p_rd_a != 0); m_rd = p_rd_a; m_data = p_d_a; m_lg = 1'b0;
      end else if (p_acc_l) begin
         m_wen = (p_rd_l != 0); m_rd = p_rd_l; m_data = p_d_l; m_lg = 1'b1;
      end else begin
         m_wen = 1'b0;
      end
   endfunction

   task automatic do_cycle(input bit va, input bit [4:0] rda, input bit [31:0] da,
                           input bit vl, input bit [4:0] rdl, input bit [31:0] dl);
      exp_t x;
      @(posedge clk);
      #1;
      model_step();
      alu_valid = va; alu_rd = rda; alu_data = da;
      lsu_valid = vl; lsu_rd = rdl; lsu_data = dl;
      x.wen = m_wen; x.rd = m_rd; x.data = m_data; x.lg = m_lg; x.busy = m_inclear;
      if (m_inclear) begin
         x.rdy_a = 1'b0; x.rdy_l = 1'b0;
      end else if (va && vl) begin
         x.rdy_a = m_lg; x.rdy_l = !m_lg;
      end else if (!va && !vl) begin
         x.rdy_a = 1'b1; x.rdy_l = 1'b1;
      end else begin
         x.rdy_a = va; x.rdy_l = vl;
      end
      sb.push_back(x);
      p_acc_a = va && x.rdy_a;
      p_acc_l = vl && x.rdy_l;
      p_rd_a = rda; p_d_a = da; p_rd_l = rdl; p_d_l = dl;
   endtask

   task automatic idle_cycle();
      do_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic rand_cycle();
      if (!ga_pend && $urandom_range(0, 2) != 0) begin
         ga_pend = 1'b1; ga_rd = 5'($urandom_range(0, 31)); ga_d = $urandom;
      end
      if (!gl_pend && $urandom_range(0, 2) != 0) begin
         gl_pend = 1'b1; gl_rd = 5'($urandom_range(0, 31)); gl_d = $urandom;
      end
      do_cycle(ga_pend, ga_rd, ga_d, gl_pend, gl_rd, gl_d);
      if (p_acc_a) ga_pend = 1'b0;
      if (p_acc_l) gl_pend = 1'b0;
   endtask

   task automatic reset_pulse();
      #2;
      mon_en = 1'b0;
      sb.delete();
      rstN = 1'b0;
      #1;
      chk("rst_async_wen", rf_wen, 0);
      chk("rst_async_rd", rf_rd, 0);
      chk("rst_async_data", rf_data, 0);
      chk("rst_async_lg", last_grant, 1);
      chk("rst_async_busy", clear_busy, 1);
      chk("rst_async_rdy", {alu_ready, lsu_ready}, 0);
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
      model_reset();
      #1;
      mon_en = 1'b1;
   endtask

   always @(negedge clk) begin
      if (clear_busy_z) busy_z_seen = 1'b1;
      if (mon_en) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: no expected entry at %0t", $time);
         end else begin
            e = sb.pop_front();
            chk("rf_wen", rf_wen, e.wen);
            chk("rf_rd", rf_rd, e.rd);
            chk("rf_data", rf_data, e.data);
            chk("last_grant", last_grant, e.lg);
            chk("clear_busy", clear_busy, e.busy);
            chk("alu_ready", alu_ready, e.rdy_a);
            chk("lsu_ready", lsu_ready, e.rdy_l);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstN = 1'b0; rstN_z = 1'b0;
      alu_valid = 1'b1; alu_rd = '0; alu_data = '0;
      lsu_valid = 1'b1; lsu_rd = '0; lsu_data = '0;
      alu_valid_z = 1'b1; alu_rd_z = '0; alu_data_z = '0;
      lsu_valid_z = 1'b0; lsu_rd_z = '0; lsu_data_z = '0;
      ga_pend = 1'b0; gl_pend = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_wen", rf_wen, 0);
      chk("reset_rd", rf_rd, 0);
      chk("reset_data", rf_data, 0);
      chk("reset_lg", last_grant, 1);
      chk("reset_busy", clear_busy, 1);
      chk("reset_rdy", {alu_ready, lsu_ready}, 0);
      chk("reset_z_rdy", alu_ready_z, 0);
      chk("reset_z_busy", clear_busy_z, 0);
      alu_valid = 1'b0; lsu_valid = 1'b0; alu_valid_z = 1'b0;
      rstN = 1'b1;
      #1;
      mon_en = 1'b1;

      repeat (32) idle_cycle();
      do_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
      idle_cycle();
      do_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
      idle_cycle();
      repeat (4) do_cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
      idle_cycle();
      repeat (300) rand_cycle();

      reset_pulse();
      repeat (10) rand_cycle();
      reset_pulse();
      repeat (150) rand_cycle();

      @(negedge clk);
      #1;
      mon_en = 1'b0;

      rstN_z = 1'b1;
      alu_valid_z = 1'b1; alu_rd_z = 5'd9; alu_data_z = 32'h1;
      #1;
      chk("z_alu_ready", alu_ready_z, 1);
      chk("z_lsu_ready", lsu_ready_z, 0);
      @(posedge clk);
      #1;
      alu_valid_z = 1'b0;
      chk("z_rf_wen", rf_wen_z, 1);
      chk("z_rf_rd", rf_rd_z, 9);
      chk("z_rf_data", rf_data_z, 32'h1);
      chk("z_last_grant", last_grant_z, 0);
      @(posedge clk);
      #1;
      chk("z_rf_wen_idle", rf_wen_z, 0);
      chk("z_rf_rd_hold", rf_rd_z, 9);
      @(negedge clk);
      chk("z_busy_never", busy_z_seen, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
